instruction_fetch_unit: RTL and testbench

Byte-serial instruction fetch unit that feeds the 32-bit instruction register path. It owns the program counter and issues byte reads to an 8-bit memory, with a variable memory wait time. It assembles four consecutive bytes big-endian, first byte most significant, matching the register's 8-bit left-shift load order. It presents the completed word with a one-cycle valid strobe.

---
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - byte-wide memory read bus between fetch unit and memory
//
// Purpose: groups the request/response handshake of the 8-bit instruction memory.
// Signals:
//   mem_read   fetch unit -> memory  read request, held until mem_valid
//   mem_addr   fetch unit -> memory  32-bit byte address
//   mem_data   memory -> fetch unit  read data byte
//   mem_valid  memory -> fetch unit  mem_data valid this cycle
// Modports: master (fetch unit side), slave (memory side).

interface instruction_fetch_unit_if;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;

  modport master (
    output mem_read,
    output mem_addr,
    input  mem_data,
    input  mem_valid
  );

  modport slave (
    input  mem_read,
    input  mem_addr,
    output mem_data,
    output mem_valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - byte-serial 32-bit instruction fetch unit
//
// Purpose: owns the program counter, reads four consecutive bytes from an
// 8-bit memory with arbitrary wait states and assembles them big-endian
// (first byte most significant) into the instruction register.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset, clears all state
//   start     in   request one 4-byte fetch (sampled only in IDLE)
//   pc_load   in   load pc from pc_in (honoured only in IDLE)
//   pc_in     in   new program counter value
//   bus       master modport: mem_read/mem_addr out, mem_data/mem_valid in
//   pc        out  program counter
//   ir        out  last completed instruction word
//   ir_valid  out  one-cycle strobe, ir just updated
//   busy      out  high while a fetch is in progress

module instruction_fetch_unit (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          pc_load,
  input  logic [31:0]                   pc_in,
  instruction_fetch_unit_if.master      bus,
  output logic [31:0]                   pc,
  output logic [31:0]                   ir,
  output logic                          ir_valid,
  output logic                          busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  cnt;        // bytes already captured in the current fetch
  logic [23:0] shift_buf;  // first three bytes, oldest in the top byte
  logic        capture;    // a byte is accepted on this edge
  logic        done;       // the accepted byte completes the word
  logic        mem_read_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and decoded outputs. mem_valid only counts while a read is
  // outstanding, so spurious strobes in IDLE never reach the datapath.
  always_comb begin
    state_next = state;
    mem_read_c = 1'b0;
    busy       = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem_read_c = 1'b1;
        busy       = 1'b1;
        if (bus.mem_valid) begin
          capture = 1'b1;
          if (cnt == 2'd3) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_read = mem_read_c;
  // Address comes straight from pc, so it only moves on a capture edge and is
  // stable for the whole request, however long the memory stalls.
  assign bus.mem_addr = pc;

  // Datapath: pc, byte counter, shift buffer, instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= 32'd0;
      ir        <= 32'd0;
      ir_valid  <= 1'b0;
      cnt       <= 2'd0;
      shift_buf <= 24'd0;
    end else begin
      ir_valid <= 1'b0;
      if (state == IDLE) begin
        // A simultaneous load and start fetches from the newly loaded pc.
        if (pc_load) begin
          pc <= pc_in;
        end
        if (start) begin
          cnt <= 2'd0;
        end
      end else if (capture) begin
        shift_buf <= {shift_buf[15:0], bus.mem_data};
        pc        <= pc + 32'd1;   // wraps modulo 2^32
        cnt       <= cnt + 2'd1;   // wraps to 0 on the fourth byte
        if (done) begin
          // ir only ever changes here, so partial words are never visible.
          ir       <= {shift_buf, bus.mem_data};
          ir_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pc_load;
  logic [31:0] pc_in;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        busy;

  int n_checks;
  int n_fails;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pc_load  (pc_load),
    .pc_in    (pc_in),
    .bus      (bus.master),
    .pc       (pc),
    .ir       (ir),
    .ir_valid (ir_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch starting in IDLE. Returns in the ir_valid cycle.
  // waits: stall cycles before each byte; noise: drive start/pc_load during
  // stalls; ld: load addr0 together with start.
  task automatic do_fetch(input logic [31:0] word, input int waits,
                          input logic [31:0] addr0, input bit noise, input bit ld);
    int e;
    logic [7:0] b;
    start   = 1'b1;
    pc_load = ld;
    pc_in   = addr0;
    step();
    start   = 1'b0;
    pc_load = 1'b0;
    e = 0;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < waits; w++) begin
        bus.mem_valid = 1'b0;
        if (noise) begin
          start   = 1'b1;
          pc_load = 1'b1;
          pc_in   = 32'h500;
        end
        expect_eq("addr_wait", bus.mem_addr, addr0 + i);
        expect_eq("no_early_valid", {31'd0, ir_valid}, 32'd0);
        step();
        e++;
      end
      start   = 1'b0;
      pc_load = 1'b0;
      b = word[31-8*i -: 8];
      bus.mem_data  = b;
      bus.mem_valid = 1'b1;
      expect_eq("addr", bus.mem_addr, addr0 + i);
      expect_eq("mem_read", {31'd0, bus.mem_read}, 32'd1);
      expect_eq("busy_fetch", {31'd0, busy}, 32'd1);
      if (i > 0) expect_eq("no_partial_valid", {31'd0, ir_valid}, 32'd0);
      step();
      e++;
      bus.mem_valid = 1'b0;
    end
    expect_eq("latency", e, 4 + 4 * waits);
    expect_eq("ir_valid", {31'd0, ir_valid}, 32'd1);
    expect_eq("ir", ir, word);
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst           = 1'b1;
    start         = 1'b0;
    pc_load       = 1'b0;
    pc_in         = 32'd0;
    bus.mem_data  = 8'd0;
    bus.mem_valid = 1'b0;
    step();
    step();
    expect_eq("rst_pc", pc, 32'd0);
    expect_eq("rst_ir", ir, 32'd0);
    expect_eq("rst_irv", {31'd0, ir_valid}, 32'd0);
    expect_eq("rst_rd", {31'd0, bus.mem_read}, 32'd0);
    expect_eq("rst_busy", {31'd0, busy}, 32'd0);
    expect_eq("rst_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait fetch from 0x100
    pc_load = 1'b1;
    pc_in   = 32'h100;
    step();
    pc_load = 1'b0;
    expect_eq("pc_load", pc, 32'h100);
    do_fetch(32'h12345678, 0, 32'h100, 1'b0, 1'b0);
    step();
    expect_eq("single_pulse", {31'd0, ir_valid}, 32'd0);
    expect_eq("pc_after", pc, 32'h104);
    expect_eq("busy_after", {31'd0, busy}, 32'd0);

    // Two wait cycles before every byte
    do_fetch(32'h9ABCDEF0, 2, 32'h104, 1'b0, 1'b0);
    step();
    expect_eq("pc_wait", pc, 32'h108);

    // Wrap-around fetch
    pc_load = 1'b1;
    pc_in   = 32'hFFFF_FFFE;
    step();
    pc_load = 1'b0;
    do_fetch(32'hAABBCCDD, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    step();
    expect_eq("pc_wrap", pc, 32'h2);

    // Spurious mem_valid in IDLE: no capture, no fetch
    bus.mem_data  = 8'h5A;
    bus.mem_valid = 1'b1;
    repeat (3) step();
    bus.mem_valid = 1'b0;
    expect_eq("idle_pc", pc, 32'h2);
    expect_eq("idle_ir", ir, 32'hAABBCCDD);
    expect_eq("idle_busy", {31'd0, busy}, 32'd0);
    expect_eq("idle_rd", {31'd0, bus.mem_read}, 32'd0);

    // start/pc_load held during stalls of a fetch are ignored
    do_fetch(32'h0BADF00D, 1, 32'h2, 1'b1, 1'b0);
    step();
    expect_eq("noise_pc", pc, 32'h6);
    expect_eq("noise_no_refetch", {31'd0, busy}, 32'd0);

    // Simultaneous load+start, then back-to-back fetch from the ir_valid cycle
    do_fetch(32'h01020304, 0, 32'h40, 1'b0, 1'b1);
    do_fetch(32'h05060708, 0, 32'h44, 1'b0, 1'b0);
    step();
    expect_eq("b2b_pc", pc, 32'h48);

    // Asynchronous reset mid-fetch after two bytes
    pc_load = 1'b1;
    pc_in   = 32'h200;
    start   = 1'b1;
    step();
    start   = 1'b0;
    pc_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_data  = 8'h11 * (i + 1);
      bus.mem_valid = 1'b1;
      step();
    end
    bus.mem_valid = 1'b0;
    expect_eq("pre_rst_pc", pc, 32'h202);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("arst_pc", pc, 32'd0);
    expect_eq("arst_rd", {31'd0, bus.mem_read}, 32'd0);
    expect_eq("arst_busy", {31'd0, busy}, 32'd0);
    expect_eq("arst_irv", {31'd0, ir_valid}, 32'd0);
    expect_eq("arst_ir", ir, 32'd0);
    step();
    rst = 1'b0;
    step();
    expect_eq("post_rst_irv", {31'd0, ir_valid}, 32'd0);
    do_fetch(32'hCAFEBABE, 0, 32'h0, 1'b0, 1'b0);
    step();
    expect_eq("post_rst_pc", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
